i8080_target: RTL and testbench

//  Responder (panel/device end) of the 8080-style parallel bus driven by our host-side I8080 controller.

---
 rtl/i8080_target.sv | 148 ++++++++++++++
 tb/tb_i8080_target.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i8080_target.sv
// i8080_target: device-side responder for an 8080-style parallel bus.
// Synchronizes the async bus, queues host writes and answers host reads.
//
// Ports:
//   clk, reset_n       system clock, async active-low reset
//   i8080_cs/rs/rd/wr  bus controls from the host (cs/rd/wr active low)
//   i8080_data_in      bus value from the pad
//   i8080_data_out/oe  readback value and pad output enable
//   m_valid/ready      write-queue stream handshake
//   m_data/m_is_data   head entry data and its rs bit
//   rd_data/rd_strobe  readback source and its capture pulse
//   overflow/_clr      sticky dropped-write flag and its clear
module i8080_target #(
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i8080_cs,
    input  logic                  i8080_rs,
    input  logic                  i8080_rd,
    input  logic                  i8080_wr,
    input  logic [DATA_WIDTH-1:0] i8080_data_in,
    output logic [DATA_WIDTH-1:0] i8080_data_out,
    output logic                  i8080_data_oe,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_is_data,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_strobe,
    output logic                  overflow,
    input  logic                  overflow_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        DRIVE
    } state_e;

    logic [SYNC_STAGES-1:0] cs_q, rs_q, rd_q, wr_q;
    logic [DATA_WIDTH-1:0]  data_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0]  data_p_q;
    logic                   wr_p_q, rd_p_q;

    logic cs_s, rs_s, rd_s, wr_s;

    assign cs_s = cs_q[SYNC_STAGES-1];
    assign rs_s = rs_q[SYNC_STAGES-1];
    assign rd_s = rd_q[SYNC_STAGES-1];
    assign wr_s = wr_q[SYNC_STAGES-1];

    // Control synchronizers plus an equal-length data delay line, so the
    // data seen at the wr rise is the value from before the rise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_q     <= '1;
            rs_q     <= '0;
            rd_q     <= '1;
            wr_q     <= '1;
            wr_p_q   <= 1'b1;
            rd_p_q   <= 1'b1;
            data_p_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) data_q[i] <= '0;
        end else begin
            cs_q     <= {cs_q[SYNC_STAGES-2:0], i8080_cs};
            rs_q     <= {rs_q[SYNC_STAGES-2:0], i8080_rs};
            rd_q     <= {rd_q[SYNC_STAGES-2:0], i8080_rd};
            wr_q     <= {wr_q[SYNC_STAGES-2:0], i8080_wr};
            wr_p_q   <= wr_s;
            rd_p_q   <= rd_s;
            data_q[0] <= i8080_data_in;
            for (int i = 1; i < SYNC_STAGES; i++) data_q[i] <= data_q[i-1];
            data_p_q <= data_q[SYNC_STAGES-1];
        end
    end

    // ---------------- write queue ----------------
    logic [DATA_WIDTH:0] mem_q [FIFO_DEPTH];
    logic [AW:0]         wptr_q, rptr_q;
    logic [DATA_WIDTH:0] head;
    logic                push, pop, full, empty, push_ok;

    assign push  = ~wr_p_q & wr_s & ~cs_s;
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop     = m_valid & m_ready;
    // A full queue refuses the push even when it pops the same cycle.
    assign push_ok = push & ~full;

    assign head      = mem_q[rptr_q[AW-1:0]];
    assign m_valid   = ~empty;
    assign m_data    = m_valid ? head[DATA_WIDTH-1:0] : '0;
    assign m_is_data = m_valid & head[DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= {rs_s, data_p_q};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            if (push && full)   overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end

    // ---------------- read responder ----------------
    state_e state_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            i8080_data_out <= '0;
            i8080_data_oe  <= 1'b0;
            rd_strobe      <= 1'b0;
        end else begin
            rd_strobe <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (rd_p_q && !rd_s && !cs_s) begin
                        i8080_data_out <= rd_data;
                        i8080_data_oe  <= 1'b1;
                        rd_strobe      <= 1'b1;
                        state_q        <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (rd_s || cs_s) begin
                        i8080_data_oe <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i8080_target.sv
// tb_i8080_target: directed-vector bench for i8080_target.
// Drives host bus cycles and checks the queue, readback and flags.
module tb_i8080_target;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs = 1'b1, rs = 1'b0, rd = 1'b1, wr = 1'b1;
    logic [15:0] din = '0;
    logic [15:0] dout;
    logic        oe;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_data;
    logic        m_is_data;
    logic [15:0] rd_data = '0;
    logic        rd_strobe;
    logic        overflow;
    logic        overflow_clr = 1'b0;

    int errs = 0;
    int checks = 0;
    int strobes = 0;
    bit mon_en = 0;
    logic [16:0] popped [$];

    i8080_target #(
        .DATA_WIDTH (16),
        .FIFO_DEPTH (16),
        .SYNC_STAGES(2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i8080_cs      (cs),
        .i8080_rs      (rs),
        .i8080_rd      (rd),
        .i8080_wr      (wr),
        .i8080_data_in (din),
        .i8080_data_out(dout),
        .i8080_data_oe (oe),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_is_data     (m_is_data),
        .rd_data       (rd_data),
        .rd_strobe     (rd_strobe),
        .overflow      (overflow),
        .overflow_clr  (overflow_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rd_strobe) strobes++;
        if (mon_en && m_valid && m_ready) popped.push_back({m_is_data, m_data});
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic c, input logic r, input logic [15:0] d);
        cs = c; rs = r; din = d;
        tick(1);
        wr = 1'b0;
        tick(3);
        wr = 1'b1;
        tick(3);
        cs = 1'b1;
        tick(1);
    endtask

    task automatic pop_check(input string tag, input logic [16:0] exp);
        chk({tag, "_valid"}, {31'b0, m_valid}, 32'd1);
        chk({tag, "_word"}, {15'b0, m_is_data, m_data}, {15'b0, exp});
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
    endtask

    initial begin
        int n;
        logic [16:0] first, last;

        tick(3);
        chk("rst_valid", {31'b0, m_valid}, 0);
        chk("rst_mdata", {16'b0, m_data}, 0);
        chk("rst_isdata", {31'b0, m_is_data}, 0);
        chk("rst_dout", {16'b0, dout}, 0);
        chk("rst_oe", {31'b0, oe}, 0);
        chk("rst_strobe", {31'b0, rd_strobe}, 0);
        chk("rst_ovf", {31'b0, overflow}, 0);
        reset_n = 1'b1;
        tick(2);

        // 1: single command write
        bus_write(1'b0, 1'b0, 16'h002C);
        pop_check("t1", {1'b0, 16'h002C});
        chk("t1_empty", {31'b0, m_valid}, 0);

        // 2: fill, overflow, drain in order
        for (int i = 1; i <= 16; i++) bus_write(1'b0, 1'b1, 16'(i));
        chk("t2_noovf", {31'b0, overflow}, 0);
        bus_write(1'b0, 1'b1, 16'h0011);
        chk("t2_ovf", {31'b0, overflow}, 1);
        for (int i = 1; i <= 16; i++) pop_check("t2_drain", {1'b1, 16'(i)});
        chk("t2_empty", {31'b0, m_valid}, 0);
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        chk("t2_clr", {31'b0, overflow}, 0);

        // 3: streaming with consumer always ready, one write per 4 clk
        popped.delete();
        m_ready = 1'b1;
        mon_en = 1;
        cs = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rs = i[0];
            din = 16'h0100 + 16'(i);
            wr = 1'b0;
            tick(2);
            wr = 1'b1;
            tick(2);
        end
        tick(6);
        cs = 1'b1;
        mon_en = 0;
        m_ready = 1'b0;
        chk("t3_count", popped.size(), 20);
        for (int i = 0; i < 20 && i < popped.size(); i++)
            chk("t3_word", {15'b0, popped[i]},
                {15'b0, i[0], 16'h0100 + 16'(i)});
        chk("t3_ovf", {31'b0, overflow}, 0);

        // 4: deselected write ignored, then a read
        bus_write(1'b1, 1'b1, 16'hBEEF);
        tick(4);
        chk("t4_nowrite", {31'b0, m_valid}, 0);
        strobes = 0;
        rd_data = 16'h5A5A;
        cs = 1'b0;
        tick(1);
        rd = 1'b0;
        n = 0;
        while (n < 10 && !oe) begin
            tick(1);
            n++;
        end
        chk("t4_oe_on", {31'b0, oe}, 1);
        chk("t4_oe_lat", {31'b0, n <= 4}, 1);
        chk("t4_dout", {16'b0, dout}, 32'h5A5A);
        tick(2);
        rd = 1'b1;
        n = 0;
        while (n < 10 && oe) begin
            tick(1);
            n++;
        end
        chk("t4_oe_off", {31'b0, oe}, 0);
        chk("t4_off_lat", {31'b0, n <= 4}, 1);
        chk("t4_strobes", strobes, 1);
        chk("t4_dout_hold", {16'b0, dout}, 32'h5A5A);
        cs = 1'b1;
        tick(2);

        // 5: full queue, push and pop on the same edge
        for (int i = 1; i <= 16; i++) bus_write(1'b0, 1'b1, 16'(i));
        chk("t5_noovf", {31'b0, overflow}, 0);
        cs = 1'b0; rs = 1'b1; din = 16'h0011;
        tick(1);
        wr = 1'b0;
        tick(3);
        wr = 1'b1;
        tick(2);
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
        chk("t5_ovf", {31'b0, overflow}, 1);
        tick(2);
        cs = 1'b1;
        n = 0;
        first = '0;
        last = '0;
        while (m_valid && n < 20) begin
            if (n == 0) first = {m_is_data, m_data};
            last = {m_is_data, m_data};
            m_ready = 1'b1;
            tick(1);
            m_ready = 1'b0;
            n++;
        end
        chk("t5_level", n, 15);
        chk("t5_first", {15'b0, first}, 32'h10002);
        chk("t5_last", {15'b0, last}, 32'h10010);
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        chk("t5_clr", {31'b0, overflow}, 0);

        // 6: reset during DRIVE with entries queued
        for (int i = 0; i < 3; i++) bus_write(1'b0, 1'b1, 16'h0A00 + 16'(i));
        chk("t6_valid", {31'b0, m_valid}, 1);
        cs = 1'b0;
        rd = 1'b0;
        tick(5);
        chk("t6_drive", {31'b0, oe}, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_oe", {31'b0, oe}, 0);
        chk("t6_rst_valid", {31'b0, m_valid}, 0);
        tick(2);
        reset_n = 1'b1;
        rd = 1'b1;
        cs = 1'b1;
        tick(3);
        bus_write(1'b0, 1'b0, 16'h0077);
        pop_check("t6_after", {1'b0, 16'h0077});
        chk("t6_empty", {31'b0, m_valid}, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
